// File: rtl/lr_seq_pkg.sv
// Shared definitions for the linear-recurrence sequence generator.
//   mode_e       : recurrence selector (Fibonacci, Padovan, Tribonacci, custom)
//   state_e      : top-level FSM states
//   TAPS_*       : lag masks for the fixed modes, bit j-1 enables lag j
//   PRELOAD_*    : 3-entry virtual pre-history, bit 2 = newest window entry
//   mode_taps    : tap mask for a fixed mode (custom returns 0; the top level
//                  substitutes the user mask)
//   mode_preload : preload pattern for a mode
package lr_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FIB    = 2'd0,
    MODE_PAD    = 2'd1,
    MODE_TRIB   = 2'd2,
    MODE_CUSTOM = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Lag masks: bit 0 = lag 1, bit 1 = lag 2, bit 2 = lag 3.
  localparam logic [2:0] TAPS_FIB  = 3'b011;
  localparam logic [2:0] TAPS_PAD  = 3'b110;
  localparam logic [2:0] TAPS_TRIB = 3'b111;

  // Pre-history seeds: bit 2 -> w[D-1], bit 1 -> w[D-2], bit 0 -> w[D-3].
  // Chosen so that the first emitted term (w[D-1]) is the classic s[0].
  localparam logic [2:0] PRELOAD_FIB    = 3'b010;
  localparam logic [2:0] PRELOAD_PAD    = 3'b010;
  localparam logic [2:0] PRELOAD_TRIB   = 3'b001;
  localparam logic [2:0] PRELOAD_CUSTOM = 3'b100;

  function automatic logic [2:0] mode_taps(input mode_e mode);
    case (mode)
      MODE_FIB:  return TAPS_FIB;
      MODE_PAD:  return TAPS_PAD;
      MODE_TRIB: return TAPS_TRIB;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] mode_preload(input mode_e mode);
    case (mode)
      MODE_FIB:  return PRELOAD_FIB;
      MODE_PAD:  return PRELOAD_PAD;
      MODE_TRIB: return PRELOAD_TRIB;
      default:   return PRELOAD_CUSTOM;
    endcase
  endfunction

endpackage

// File: rtl/lr_seq_sum.sv
// Combinational masked adder over the history window.
//   window : DEPTH entries of WIDTH bits, entry k at [k*WIDTH +: WIDTH],
//            entry DEPTH-1 is the newest term
//   taps   : bit j-1 enables lag j, i.e. adds window entry DEPTH-j
//   sum    : full sum reduced modulo 2^WIDTH
//   ovf    : full sum exceeded 2^WIDTH-1
module lr_seq_sum #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic [DEPTH*WIDTH-1:0] window,
  input  logic [DEPTH-1:0]       taps,
  output logic [WIDTH-1:0]       sum,
  output logic                   ovf
);

  // Wide enough that adding DEPTH WIDTH-bit terms can never wrap.
  localparam int SUM_W = WIDTH + $clog2(DEPTH + 1);

  logic [SUM_W-1:0] term [DEPTH];
  logic [SUM_W-1:0] acc;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_term
      // Lag gi+1 reads entry DEPTH-1-gi.
      assign term[gi] = taps[gi] ? SUM_W'(window[(DEPTH-1-gi)*WIDTH +: WIDTH])
                                 : '0;
    end
  endgenerate

  always_comb begin
    acc = '0;
    for (int k = 0; k < DEPTH; k++) begin
      acc = acc + term[k];
    end
  end

  assign sum = acc[WIDTH-1:0];
  assign ovf = |acc[SUM_W-1:WIDTH];

endmodule

// File: rtl/lr_seq_generator.sv
// Linear-recurrence sequence generator with start/length control and a
// valid/ready output stream.
//   clk, reset  : clock and synchronous active-high reset
//   start_i     : begin a sequence (only honoured when idle)
//   mode_i      : recurrence select, latched on start
//   tap_mask_i  : custom lag mask (mode 3), latched on start
//   length_i    : terms to emit, 0 = unbounded, latched on start
//   ready_i     : consumer accepts the presented term
//   valid_o     : seq_o/index_o carry a term
//   seq_o       : current term
//   index_o     : index of the current term (wraps)
//   busy_o      : not idle
//   done_o      : one-cycle pulse after the last term is accepted
//   ovf_o       : sticky, some emitted term wrapped modulo 2^WIDTH
module lr_seq_generator
  import lr_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [DEPTH-1:0] tap_mask_i,
  input  logic [CNT_W-1:0] length_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] seq_o,
  output logic [CNT_W-1:0] index_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             ovf_o
);

  state_e                 state_reg, state_next;
  logic [DEPTH*WIDTH-1:0] window_reg;
  logic [CNT_W-1:0]       index_reg;
  logic [CNT_W-1:0]       length_reg;
  logic [DEPTH-1:0]       taps_reg;
  logic                   ovf_reg;

  mode_e                  mode_start;
  logic [DEPTH-1:0]       taps_start;
  logic [2:0]             preload_bits;
  logic [DEPTH*WIDTH-1:0] window_preload;
  logic [DEPTH*WIDTH-1:0] window_shifted;
  logic [WIDTH-1:0]       next_term;
  logic                   next_ovf;
  logic                   load;
  logic                   shift;

  assign mode_start   = mode_e'(mode_i);
  assign preload_bits = mode_preload(mode_start);

  always_comb begin
    taps_start = '0;
    if (mode_start == MODE_CUSTOM) begin
      taps_start = tap_mask_i;
    end else begin
      taps_start[2:0] = mode_taps(mode_start);
    end
  end

  // Only the three newest entries are seeded; older history starts at 0.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_preload
      if (gi >= DEPTH - 3) begin : g_seed
        assign window_preload[gi*WIDTH +: WIDTH] = WIDTH'(preload_bits[gi-(DEPTH-3)]);
      end else begin : g_zero
        assign window_preload[gi*WIDTH +: WIDTH] = '0;
      end
    end
  endgenerate

  lr_seq_sum #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_sum (
    .window (window_reg),
    .taps   (taps_reg),
    .sum    (next_term),
    .ovf    (next_ovf)
  );

  // Oldest entry drops out of the bottom, new term enters at the top.
  assign window_shifted = {next_term, window_reg[DEPTH*WIDTH-1:WIDTH]};

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (ready_i) begin
          // The last term of a bounded run is not followed by a shift, so
          // the window and index freeze on the final term.
          if ((length_reg != '0) && (index_reg == length_reg - CNT_W'(1))) begin
            state_next = DONE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      window_reg <= '0;
      index_reg  <= '0;
      length_reg <= '0;
      taps_reg   <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        window_reg <= window_preload;
        index_reg  <= '0;
        length_reg <= length_i;
        taps_reg   <= taps_start;
        ovf_reg    <= 1'b0;
      end else if (shift) begin
        window_reg <= window_shifted;
        index_reg  <= index_reg + CNT_W'(1);
        ovf_reg    <= ovf_reg | next_ovf;
      end
    end
  end

  assign valid_o = (state_reg == RUN);
  assign done_o  = (state_reg == DONE);
  assign busy_o  = (state_reg != IDLE);
  assign seq_o   = window_reg[DEPTH*WIDTH-1 -: WIDTH];
  assign index_o = index_reg;
  assign ovf_o   = ovf_reg;

endmodule

// File: tb/tb_lr_seq_generator.sv
module tb_lr_seq_generator;

  typedef struct {
    logic [31:0] seq;
    logic [15:0] idx;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        reset;

  // 32-bit instance
  logic        start32, ready32;
  logic [1:0]  mode32;
  logic [3:0]  mask32;
  logic [15:0] len32;
  logic        valid32, busy32, done32, ovf32;
  logic [31:0] seq32;
  logic [15:0] idx32;

  // 8-bit instance for overflow
  logic        start8, ready8;
  logic [1:0]  mode8;
  logic [3:0]  mask8;
  logic [15:0] len8;
  logic        valid8, busy8, done8, ovf8;
  logic [7:0]  seq8;
  logic [15:0] idx8;

  exp_t q32[$];
  exp_t q8[$];

  int checks = 0;
  int errors = 0;
  logic [15:0] pat = 16'b0110_1001_1101_0011;

  lr_seq_generator #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut32 (
    .clk(clk), .reset(reset), .start_i(start32), .mode_i(mode32),
    .tap_mask_i(mask32), .length_i(len32), .ready_i(ready32),
    .valid_o(valid32), .seq_o(seq32), .index_o(idx32), .busy_o(busy32),
    .done_o(done32), .ovf_o(ovf32)
  );

  lr_seq_generator #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut8 (
    .clk(clk), .reset(reset), .start_i(start8), .mode_i(mode8),
    .tap_mask_i(mask8), .length_i(len8), .ready_i(ready8),
    .valid_o(valid8), .seq_o(seq8), .index_o(idx8), .busy_o(busy8),
    .done_o(done8), .ovf_o(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input longint unsigned got,
                              input longint unsigned want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endfunction

  function automatic void push32(input logic [31:0] s, input logic [15:0] i);
    exp_t e;
    e.seq = s; e.idx = i; e.ovf = 1'b0;
    q32.push_back(e);
  endfunction

  // Monitor for the 32-bit instance: checks each accepted term against the
  // scoreboard and checks that a stalled term holds still.
  logic        hold32 = 1'b0;
  logic [31:0] hseq32;
  logic [15:0] hidx32;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold32 = 1'b0;
    end else begin
      if (hold32) begin
        chk("stall_valid32", valid32, 1);
        chk("stall_seq32", seq32, hseq32);
        chk("stall_idx32", idx32, hidx32);
      end
      if (valid32 && ready32) begin
        if (q32.size() == 0) begin
          chk("unexpected_term32", idx32, 16'hFFFF);
        end else begin
          e = q32.pop_front();
          chk("seq32", seq32, e.seq);
          chk("idx32", idx32, e.idx);
          chk("ovf32", ovf32, e.ovf);
        end
      end
      hold32 = valid32 && !ready32;
      hseq32 = seq32;
      hidx32 = idx32;
    end
  end

  logic       hold8 = 1'b0;
  logic [7:0] hseq8;
  logic [15:0] hidx8;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      hold8 = 1'b0;
    end else begin
      if (hold8) begin
        chk("stall_valid8", valid8, 1);
        chk("stall_seq8", seq8, hseq8);
        chk("stall_idx8", idx8, hidx8);
      end
      if (valid8 && ready8) begin
        if (q8.size() == 0) begin
          chk("unexpected_term8", idx8, 16'hFFFF);
        end else begin
          e = q8.pop_front();
          chk("seq8", seq8, e.seq);
          chk("idx8", idx8, e.idx);
          chk("ovf8", ovf8, e.ovf);
        end
      end
      hold8 = valid8 && !ready8;
      hseq8 = seq8;
      hidx8 = idx8;
    end
  end

  // Start a bounded run on the 32-bit instance and follow it to DONE.
  // Controls are scrambled right after the start edge to prove latching.
  task automatic run32(input logic [1:0] m, input logic [3:0] tm,
                       input logic [15:0] len, input bit bp);
    int cyc;
    @(posedge clk); #1;
    mode32 = m; mask32 = tm; len32 = len; start32 = 1'b1; ready32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; mode32 = 2'd2; mask32 = 4'b0101; len32 = 16'd0;
    @(negedge clk);
    chk("first_valid", valid32, 1);
    chk("busy_run", busy32, 1);
    cyc = 0;
    while (!done32 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      ready32 = bp ? pat[cyc % 16] : 1'b1;
      @(negedge clk);
    end
    ready32 = 1'b1;
    if (cyc >= 300) begin
      chk("done_timeout", cyc, 0);
    end else begin
      chk("done_valid_low", valid32, 0);
      @(negedge clk);
      chk("done_one_cycle", done32, 0);
      chk("idle_after_done", busy32, 0);
      chk("all_terms_seen", q32.size(), 0);
    end
  endtask

  initial begin
    int fib[8]   = '{0, 1, 1, 2, 3, 5, 8, 13};
    int pad[10]  = '{0, 1, 1, 1, 2, 2, 3, 4, 5, 7};
    int trib[6]  = '{0, 1, 1, 2, 4, 7};
    int cust[8]  = '{1, 0, 0, 0, 1, 0, 0, 0};
    int f8[16]   = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121, 98};
    int cyc;
    exp_t e;

    reset = 1'b1;
    start32 = 1'b0; ready32 = 1'b0; mode32 = 2'd0; mask32 = 4'd0; len32 = 16'd0;
    start8 = 1'b0; ready8 = 1'b0; mode8 = 2'd0; mask8 = 4'd0; len8 = 16'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid32, 0);
    chk("rst_seq", seq32, 0);
    chk("rst_idx", idx32, 0);
    chk("rst_busy", busy32, 0);
    chk("rst_done", done32, 0);
    chk("rst_ovf", ovf32, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", valid32, 0);

    // Fibonacci, Padovan, Tribonacci
    for (int i = 0; i < 8; i++) push32(fib[i], 16'(i));
    run32(2'd0, 4'd0, 16'd8, 1'b0);
    for (int i = 0; i < 10; i++) push32(pad[i], 16'(i));
    run32(2'd1, 4'd0, 16'd10, 1'b0);
    for (int i = 0; i < 6; i++) push32(trib[i], 16'(i));
    run32(2'd2, 4'd0, 16'd6, 1'b0);

    // Fibonacci under backpressure
    for (int i = 0; i < 8; i++) push32(fib[i], 16'(i));
    run32(2'd0, 4'd0, 16'd8, 1'b1);

    // Custom impulse response, lag 4 only
    for (int i = 0; i < 8; i++) push32(cust[i], 16'(i));
    run32(2'd3, 4'b1000, 16'd8, 1'b0);

    // start ignored while running, then reset with index 5 on the output
    for (int i = 0; i < 6; i++) push32(fib[i], 16'(i));
    @(posedge clk); #1;
    mode32 = 2'd0; len32 = 16'd20; start32 = 1'b1; ready32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    @(posedge clk); #1;
    start32 = 1'b1; mode32 = 2'd2; len32 = 16'd3;
    @(posedge clk); #1;
    start32 = 1'b0; mode32 = 2'd0; len32 = 16'd0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (idx32 != 16'd5 && cyc < 50);
    chk("reach_idx5", idx32, 5);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", valid32, 0);
    chk("mid_rst_seq", seq32, 0);
    chk("mid_rst_idx", idx32, 0);
    chk("mid_rst_busy", busy32, 0);
    chk("mid_rst_done", done32, 0);
    chk("mid_rst_ovf", ovf32, 0);
    chk("mid_rst_terms", q32.size(), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", valid32, 0);
    for (int i = 0; i < 8; i++) push32(fib[i], 16'(i));
    run32(2'd0, 4'd0, 16'd8, 1'b0);

    // Overflow on the 8-bit instance, unbounded Fibonacci
    for (int i = 0; i < 16; i++) begin
      e.seq = 32'(f8[i]); e.idx = 16'(i); e.ovf = (i >= 14);
      q8.push_back(e);
    end
    @(posedge clk); #1;
    start8 = 1'b1; ready8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (idx8 != 16'd15 && cyc < 50);
    chk("reach_idx15", idx8, 15);
    #1 ready8 = 1'b0;
    repeat (3) @(negedge clk);
    chk("ovf_sticky", ovf8, 1);
    chk("ovf_hold_valid", valid8, 1);
    chk("ovf_terms_seen", q8.size(), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("ovf_cleared", ovf8, 0);
    chk("ovf_rst_valid", valid8, 0);
    chk("ovf_rst_busy", busy8, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lr_seq_generator.md
# lr_seq_generator

Parametrised linear-recurrence sequence generator: s[n] = sum of s[n-j] over enabled lags j in 1..DEPTH, with selectable Fibonacci, Padovan, Tribonacci or custom tap sets. It adds over the fixed-recurrence generator:
- start/length control;
- a valid/ready output stream with term index;
- a sticky overflow flag.

It feeds downstream test-pattern and stimulus consumers, one term per accepted handshake.

## Interface
- WIDTH, 32, term width in bits
- DEPTH, 4, history depth and maximum lag; must be >= 3
- CNT_W, 16, width of length_i and index_o
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- start_i  input  1  begin a new sequence; honoured only in IDLE
- mode_i  input  2  0 Fibonacci (lags 1,2), 1 Padovan (lags 2,3), 2 Tribonacci (lags 1,2,3), 3 custom; latched on start
- tap_mask_i  input  DEPTH  custom lags: bit j-1 enables lag j; latched on start, used only in mode 3
- length_i  input  CNT_W  number of terms to emit, 0 = unbounded; latched on start
- ready_i  input  1  consumer accepts seq_o
- valid_o  output  1  seq_o/index_o hold a term
- seq_o  output  WIDTH  current term s[index_o]
- index_o  output  CNT_W  term index, starts at 0, wraps modulo 2^CNT_W
- busy_o  output  1  FSM not in IDLE
- done_o  output  1  one-cycle pulse after the last term is accepted
- ovf_o  output  1  sticky: some emitted term wrapped modulo 2^WIDTH

## Operation
- History window w[0..DEPTH-1], w[DEPTH-1] newest; seq_o = w[DEPTH-1].
- Next term = sum over enabled lags j of w[DEPTH-j]. Computed in WIDTH+$clog2(DEPTH+1) bits, stored modulo 2^WIDTH.
- Start preload holds virtual pre-history (newest first: w[D-1], w[D-2], w[D-3]); all other entries are 0:
  - Fibonacci: 0,1,0
  - Padovan: 0,1,0
  - Tribonacci: 0,0,1
  - custom: 1,0,0
- Resulting first terms:
  - Fibonacci 0,1,1,2,3,5…
  - Padovan 0,1,1,1,2,2,3,4…
  - Tribonacci 0,1,1,2,4,7…
  - custom: impulse response starting at 1
- FSM states:
  - IDLE: valid_o=0. On start_i: load window, index=0, clear ovf_o, latch controls, go RUN.
  - RUN: valid_o=1. On valid_o&ready_i: shift window (w[k]<=w[k+1], w[D-1]<=next), index++. If length≠0 and the accepted term had index length-1, go DONE without shifting.
  - DONE: valid_o=0, done_o=1 for one cycle, then IDLE.
- Overflow: when a shifted-in term's full-width sum exceeds 2^WIDTH-1, ovf_o sets in the same cycle that term appears on seq_o. It holds until the next start or reset.
- tap_mask_i = 0 in custom mode: every generated term is 0, which is legal.
- start_i in RUN/DONE is ignored; in-flight controls are not disturbed.
- Reset at any time: IDLE, window 0, valid_o=0, seq_o=0, index_o=0, busy_o=0, done_o=0, ovf_o=0. No term is emitted in the reset cycle or the cycle after.

## Timing
- start_i sampled at edge t: valid_o=1 with s[0] from t+1.
- ready_i held high: one term per cycle, zero bubbles.
- ready_i low: seq_o, index_o and valid_o hold stable. This is an AXI-style rule: valid_o never drops without acceptance, except on reset.
- Last term accepted at edge t: done_o=1 and valid_o=0 during t+1; IDLE at t+2. A new start_i is accepted at t+2 or later.
- Unbounded mode: runs until reset. index_o wraps silently and never triggers DONE.

## Structure
- Package lr_seq_pkg:
  - mode_e enum (MODE_FIB, MODE_PAD, MODE_TRIB, MODE_CUSTOM);
  - state_e (IDLE, RUN, DONE);
  - per-mode tap-mask and 3-entry preload constants;
  - a function returning the tap mask for a mode.
- Sub-module lr_seq_sum: combinational masked adder tree over the window. Outputs the WIDTH-bit sum and an overflow bit.
- Top level holds the FSM, window registers, counter and flags.

## Test plan
- Fibonacci, WIDTH=32, DEPTH=4, length=8, ready_i=1 -> terms 0,1,1,2,3,5,8,13 on index 0..7, then done_o pulse, then busy_o=0.
- Padovan, length=10 -> 0,1,1,1,2,2,3,4,5,7. Tribonacci, length=6 -> 0,1,1,2,4,7.
- Backpressure: Fibonacci with ready_i toggled randomly -> accepted stream identical to the first scenario; seq_o and index_o stable while ready_i=0.
- Overflow, WIDTH=8, Fibonacci, unbounded -> index 13 = 233 with ovf_o=0; index 14 = 121 with ovf_o=1; ovf_o stays 1 until the next start_i.
- Custom, DEPTH=4, tap_mask=4'b1000, length=8 -> 1,0,0,0,1,0,0,0.
- Reset asserted mid-RUN at index 5 -> next cycle all outputs at reset values. start_i ignored while busy; a fresh start after reset restarts at index 0.
